// File: rtl/fsm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fsm_seq_pkg
// Brief   : Shared constants and entry helpers for the fsm_seq_driver block.
// Revision: 1.0 - initial release
// ============================================================================
package fsm_seq_pkg;

    localparam int ENTRY_W = 3;
    localparam int SYM_LSB = 0;
    localparam int EXP_BIT = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLR   = 3'd1;
    localparam state_t ST_PLAY  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic [1:0] entry_sym(input logic [ENTRY_W-1:0] e);
        return e[SYM_LSB +: 2];
    endfunction

    function automatic logic entry_exp(input logic [ENTRY_W-1:0] e);
        return e[EXP_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : fsm_seq_if
// Brief   : Host-side programming, control and result bus of fsm_seq_driver.
// Revision: 1.0 - initial release
// ============================================================================
interface fsm_seq_if
    import fsm_seq_pkg::*;
#(
    parameter int AW    = 4,
    parameter int CNT_W = 8
) ();

    logic               i_wr_en;
    logic [AW-1:0]      i_wr_addr;
    logic [ENTRY_W-1:0] i_wr_data;
    logic [AW:0]        i_len;
    logic               i_start;
    logic               o_busy;
    logic               o_done;
    logic [CNT_W-1:0]   o_err_cnt;
    logic               o_first_err_vld;
    logic [AW-1:0]      o_first_err_idx;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_len, i_start,
        input  o_busy, o_done, o_err_cnt, o_first_err_vld, o_first_err_idx
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_len, i_start,
        output o_busy, o_done, o_err_cnt, o_first_err_vld, o_first_err_idx
    );

endinterface
`default_nettype wire

// File: rtl/fsm_seq_mem.sv
`default_nettype none
// ============================================================================
// Module  : fsm_seq_mem
// Brief   : DEPTH x ENTRY_W sequence store, one sync write, one async read.
// Revision: 1.0 - initial release
// ============================================================================
module fsm_seq_mem
    import fsm_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic [AW-1:0]      i_rd_addr,
    output logic [ENTRY_W-1:0] o_rd_data
);

    // Contents intentionally survive reset so a sequence can be replayed.
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/fsm_seq_driver.sv
`default_nettype none
// ============================================================================
// Module  : fsm_seq_driver
// Brief   : Plays a stored symbol sequence into a Moore FSM and checks it.
// Revision: 1.0 - initial release
// ============================================================================
module fsm_seq_driver
    import fsm_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int CLR_CYC = 2,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    fsm_seq_if.slave   bus,
    output logic       o_dut_rstn,
    output logic [1:0] o_sym,
    input  logic       i_dut_out
);

    localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    state_t             r_state;
    state_t             w_state_nx;
    logic [CLR_W-1:0]   r_clr_cnt;
    logic [AW-1:0]      r_idx;
    logic [AW:0]        r_len;
    logic [ENTRY_W-1:0] w_rd_data;

    logic               w_start_ok;
    logic               w_len_zero;
    logic [AW:0]        w_len_clamp;
    logic               w_clr_last;
    logic               w_play_last;

    // Two-stage check pipeline: output register, then DUT register.
    logic               r_chk1_vld;
    logic               r_chk1_exp;
    logic [AW-1:0]      r_chk1_idx;
    logic               r_chk2_vld;
    logic               r_chk2_exp;
    logic [AW-1:0]      r_chk2_idx;

    logic               r_busy;
    logic               r_done;
    logic               r_dut_rstn;
    logic [1:0]         r_sym;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_first_vld;
    logic [AW-1:0]      r_first_idx;

    logic               w_busy_nx;
    logic               w_done_nx;
    logic               w_dut_rstn_nx;
    logic [1:0]         w_sym_nx;

    fsm_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (bus.i_wr_en && (r_state == ST_IDLE)),
        .i_wr_addr (bus.i_wr_addr),
        .i_wr_data (bus.i_wr_data),
        .i_rd_addr (r_idx),
        .o_rd_data (w_rd_data)
    );

    assign w_start_ok  = (r_state == ST_IDLE) && bus.i_start;
    assign w_len_zero  = (bus.i_len == '0);
    assign w_len_clamp = (bus.i_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.i_len;
    assign w_clr_last  = (r_clr_cnt == CLR_W'(CLR_CYC - 1));
    assign w_play_last = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok && !w_len_zero) w_state_nx = ST_CLR;
            ST_CLR:   if (w_clr_last)                w_state_nx = ST_PLAY;
            ST_PLAY:  if (w_play_last)               w_state_nx = ST_DRAIN;
            ST_DRAIN:                                w_state_nx = ST_DONE;
            ST_DONE:                                 w_state_nx = ST_IDLE;
            default:                                 w_state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; they lag the state by one cycle.
    always_comb begin
        w_busy_nx     = (w_state_nx != ST_IDLE);
        w_done_nx     = (r_state == ST_DONE) || (w_start_ok && w_len_zero);
        w_dut_rstn_nx = (r_state == ST_PLAY) || (r_state == ST_DRAIN);
        w_sym_nx      = 2'b00;
        if (r_state == ST_PLAY) begin
            w_sym_nx = entry_sym(w_rd_data);
        end else if (r_state == ST_DRAIN) begin
            w_sym_nx = r_sym;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt   <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_chk1_vld  <= 1'b0;
            r_chk1_exp  <= 1'b0;
            r_chk1_idx  <= '0;
            r_chk2_vld  <= 1'b0;
            r_chk2_exp  <= 1'b0;
            r_chk2_idx  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dut_rstn  <= 1'b0;
            r_sym       <= 2'b00;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
        end else begin
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_dut_rstn <= w_dut_rstn_nx;
            r_sym      <= w_sym_nx;

            r_clr_cnt <= (r_state == ST_CLR)  ? r_clr_cnt + CLR_W'(1) : '0;
            r_idx     <= (r_state == ST_PLAY) ? r_idx + AW'(1)        : '0;

            if (w_start_ok && !w_len_zero) begin
                r_len <= w_len_clamp;
            end

            r_chk1_vld <= (r_state == ST_PLAY);
            r_chk1_exp <= entry_exp(w_rd_data);
            r_chk1_idx <= r_idx;
            r_chk2_vld <= r_chk1_vld;
            r_chk2_exp <= r_chk1_exp;
            r_chk2_idx <= r_chk1_idx;

            if (w_start_ok && !w_len_zero) begin
                r_err_cnt   <= '0;
                r_first_vld <= 1'b0;
                r_first_idx <= '0;
            end else if (r_chk2_vld && (i_dut_out != r_chk2_exp)) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                if (!r_first_vld) begin
                    r_first_vld <= 1'b1;
                    r_first_idx <= r_chk2_idx;
                end
            end
        end
    end

    assign bus.o_busy          = r_busy;
    assign bus.o_done          = r_done;
    assign bus.o_err_cnt       = r_err_cnt;
    assign bus.o_first_err_vld = r_first_vld;
    assign bus.o_first_err_idx = r_first_idx;
    assign o_dut_rstn          = r_dut_rstn;
    assign o_sym               = r_sym;

endmodule
`default_nettype wire
